conv1_ctrl: RTL and testbench
=============================

# conv1_ctrl

Sequencer for the Convolution 1 layer. On `start` it loads both 5x5 kernels from weight memory into the kernel register bank, using two read ports: kernel 0 at words 0–24 and kernel 1 at words 25–49. It then walks every 5x5 window of the 28x28 input image memory, drives the dual-kernel MAC datapath, and hands each 24x24 result to the output-memory writer over a valid/ready handshake.

## Interface
Parameters:
- `IMG_W`, 28, input image width and height.
- `K`, 5, kernel width and height.
- `K1_BASE`, 25, weight-memory base address of kernel 1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin one layer pass; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the pass completes.
- `k_addr0`, `k_addr1`  out  6  weight-memory read addresses for kernel 0 and kernel 1.
- `k_re`  out  1  weight read strobe.
- `k_we`  out  1  kernel-bank write enable, one cycle after `k_re`.
- `k_idx`  out  5  kernel-bank tap index (0–24), aligned with `k_we`.
- `img_addr`  out  10  image-memory read address.
- `img_re`  out  1  image read strobe.
- `mac_en`  out  1  accumulate enable, one cycle after `img_re`.
- `mac_clear`  out  1  load the product instead of accumulating; asserted with the first `mac_en` of each window.
- `mac_last`  out  1  asserted with the 25th `mac_en` of each window.
- `tap`  out  5  kernel tap index (0–24), aligned with `mac_en`.
- `out_valid`  out  1  MAC result for `out_addr` is ready to write.
- `out_ready`  in  1  writer accepts the result.
- `out_addr`  out  10  output pixel index, equal to orow*24+ocol (0–575).

## Operation
States: IDLE, LOAD, CONV, DRAIN, WRITE, DONE.
- **IDLE:** on `start`, go to LOAD. All counters clear.
- **LOAD:** runs 26 cycles.
  - Issue cycles i = 0..24: `k_re`=1, `k_addr0`=i, `k_addr1`=K1_BASE+i.
  - Write cycles 1..25: `k_we`=1, `k_idx`=i−1.
  - After the 26th cycle, go to CONV with orow=ocol=0.
- **CONV:** runs 25 cycles, taps t = kr*5+kc, row-major.
  - `img_re`=1 and `img_addr`=(orow+kr)*28+ocol+kc.
  - Address is formed from a window-base register plus a row-offset accumulator (+1 per column, +24 at row wrap). No multipliers.
  - `mac_en` and `tap` follow `img_re` by one cycle. `mac_clear` is set at t=0, `mac_last` at t=24.
- **DRAIN:** one cycle. Carries the final `mac_en`/`mac_last`. No read is issued.
- **WRITE:** `out_valid`=1 and `out_addr` is held until `out_ready`.
  - On handshake with `out_addr`=575, go to DONE.
  - Otherwise advance ocol. When ocol=23, wrap ocol to 0 and increment orow. Then go to CONV.
- **DONE:** `done`=1 for one cycle, then IDLE.

Rules that apply in all states:
- `start` outside IDLE is ignored.
- The window base advances by +1 per pixel and by +5 at output-row wrap (skipping the 4 columns that cannot start a window).
- Address ranges: `img_addr` ≤ 783, `k_addr1` ≤ 49. No wrap occurs inside the legal range.

## Timing
- Reset is asynchronous and active-low. It returns the block to IDLE from any state, mid-pass included.
- Reset value of every output is 0, including address and index buses.
- Mid-pass reset discards partial results. A new `start` reloads the kernels.
- All outputs are registered. Weight and image memories have one-cycle read latency.
- Per-pixel cost is 27 cycles (25 CONV + 1 DRAIN + 1 WRITE) when `out_ready` is held high. Each stalled cycle adds 1.
- With `start` at cycle 0: LOAD occupies cycles 1–26, the first CONV is at 27, the first `out_valid` at 53, and `done` at 15579 when `out_ready` is always 1.
- `out_valid` never drops without a handshake. `out_addr` is stable while `out_valid`=1 and `out_ready`=0.

## Structure
- Package `conv1_pkg`:
  - state enum `conv1_state_t`;
  - constants IMG_W=28, K=5, OUT_W=24, N_TAPS=25, N_OUT=576, K1_BASE=25;
  - address widths 6 and 10.
- Sub-module `conv1_win_addr`: window-base and tap counters producing `img_addr`, `tap`, the first/last-tap flags, and `out_addr`. It takes `step_tap` and `step_pixel` from the FSM.
- The FSM and the LOAD counter live in `conv1_ctrl`.

## Test plan
- **Kernel load:** reset, then `start` → `k_addr0`/`k_addr1` step 0/25 … 24/49 on cycles 1–25. `k_we` on cycles 2–26 with `k_idx` 0–24. CONV begins at cycle 27.
- **First window:** the `img_addr` sequence is 0,1,2,3,4,28,…,116. `mac_clear` comes with the first `mac_en`, `mac_last` with the 25th. `out_valid` with `out_addr`=0 appears at cycle 53.
- **Row wrap:** the pixel after `out_addr`=23 has first `img_addr`=28 and `out_addr`=24. The last window (575) has first `img_addr`=667 and last `img_addr`=783.
- **Backpressure:** hold `out_ready`=0 for 10 cycles at pixel 100 → `out_valid` and `out_addr`=100 are held stable, no `img_re` is issued, and `done` slips by 10 cycles.
- **Full pass:** `out_ready`=1 throughout → 576 handshakes, `done` at cycle 15579, `busy` falls the next cycle, and `start` asserted during the pass is ignored.
- **Mid-pass reset:** assert reset during CONV of pixel 300 → all outputs are 0 immediately. A following `start` replays the LOAD sequence from address 0.

Source files
------------

// File: rtl/conv1_pkg.sv
// Shared constants and state encoding for the Convolution 1 layer sequencer.
package conv1_pkg;

    localparam int IMG_W   = 28;
    localparam int K       = 5;
    localparam int OUT_W   = IMG_W - K + 1;
    localparam int N_TAPS  = K * K;
    localparam int N_OUT   = OUT_W * OUT_W;
    localparam int K1_BASE = 25;
    localparam int KA_W    = 6;
    localparam int IA_W    = 10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CONV  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CONV  = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } conv1_state_t;

endpackage

// File: rtl/conv1_win_addr.sv
// Window-base and tap counters: holds the current image read address, tap
// index and output pixel index for the 5x5 window walk.
module conv1_win_addr
    import conv1_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int K     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             step_tap,
    input  logic             step_pixel,
    output logic [IA_W-1:0]  img_addr,
    output logic [4:0]       tap,
    output logic             first_tap,
    output logic             last_tap,
    output logic             last_pixel,
    output logic [IA_W-1:0]  out_addr
);

    localparam int OW = IMG_W - K + 1;
    localparam logic [IA_W-1:0] ROW_STEP = IA_W'(OW);
    localparam logic [IA_W-1:0] WRAP_STEP = IA_W'(K);
    localparam logic [IA_W-1:0] OUT_LAST = IA_W'(OW * OW - 1);
    localparam logic [4:0] TAP_LAST = 5'(K * K - 1);
    localparam logic [2:0] KC_LAST = 3'(K - 1);
    localparam logic [4:0] OCOL_LAST = 5'(OW - 1);

    logic [IA_W-1:0] base;
    logic [IA_W-1:0] next_base;
    logic [2:0]      kc;
    logic [4:0]      ocol;

    // Skipping the K-1 columns that cannot start a window at output-row wrap.
    assign next_base  = (ocol == OCOL_LAST) ? base + WRAP_STEP : base + 1'b1;
    assign first_tap  = (tap == 5'd0);
    assign last_tap   = (tap == TAP_LAST);
    assign last_pixel = (out_addr == OUT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base     <= '0;
            img_addr <= '0;
            kc       <= '0;
            tap      <= '0;
            ocol     <= '0;
            out_addr <= '0;
        end else if (clear) begin
            base     <= '0;
            img_addr <= '0;
            kc       <= '0;
            tap      <= '0;
            ocol     <= '0;
            out_addr <= '0;
        end else if (step_pixel) begin
            base     <= next_base;
            img_addr <= next_base;
            kc       <= '0;
            tap      <= '0;
            ocol     <= (ocol == OCOL_LAST) ? 5'd0 : ocol + 5'd1;
            out_addr <= out_addr + 1'b1;
        end else if (step_tap) begin
            if (last_tap) begin
                tap      <= '0;
                kc       <= '0;
                img_addr <= base;
            end else begin
                tap <= tap + 5'd1;
                if (kc == KC_LAST) begin
                    kc       <= '0;
                    img_addr <= img_addr + ROW_STEP;
                end else begin
                    kc       <= kc + 3'd1;
                    img_addr <= img_addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/conv1_ctrl.sv
// Convolution 1 layer sequencer: kernel load, window walk driving the MAC,
// and valid/ready hand-off of each output pixel.
module conv1_ctrl
    import conv1_pkg::*;
#(
    parameter int IMG_W   = 28,
    parameter int K       = 5,
    parameter int K1_BASE = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [KA_W-1:0]  k_addr0,
    output logic [KA_W-1:0]  k_addr1,
    output logic             k_re,
    output logic             k_we,
    output logic [4:0]       k_idx,
    output logic [IA_W-1:0]  img_addr,
    output logic             img_re,
    output logic             mac_en,
    output logic             mac_clear,
    output logic             mac_last,
    output logic [4:0]       tap,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IA_W-1:0]  out_addr,
    output conv1_state_t     dbg_state
);

    // Handshake: a result transfers on a rising edge where out_valid and
    // out_ready are both high; out_valid and out_addr hold until then.

    localparam logic [4:0] LOAD_LAST = 5'(K * K);

    logic [2:0] state, state_d;
    logic [4:0] load_cnt, load_cnt_d;
    logic       k_issue;
    logic       win_clear, step_tap, step_pixel;
    logic [4:0] w_tap;
    logic       w_first, w_last, w_last_pix;

    conv1_win_addr #(.IMG_W(IMG_W), .K(K)) u_win (
        .clk        (clk),
        .reset      (reset),
        .clear      (win_clear),
        .step_tap   (step_tap),
        .step_pixel (step_pixel),
        .img_addr   (img_addr),
        .tap        (w_tap),
        .first_tap  (w_first),
        .last_tap   (w_last),
        .last_pixel (w_last_pix),
        .out_addr   (out_addr)
    );

    assign dbg_state = conv1_state_t'(state);

    always_comb begin
        state_d    = state;
        load_cnt_d = '0;
        win_clear  = 1'b0;
        step_tap   = 1'b0;
        step_pixel = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    win_clear = 1'b1;
                end
            end
            ST_LOAD: begin
                if (load_cnt == LOAD_LAST) state_d = ST_CONV;
                else load_cnt_d = load_cnt + 5'd1;
            end
            ST_CONV: begin
                step_tap = 1'b1;
                if (w_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = ST_WRITE;
            ST_WRITE: begin
                if (out_ready) begin
                    if (w_last_pix) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_CONV;
                        step_pixel = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with
    // the state they belong to; the k_we/mac_* group is a one-cycle delay.
    assign k_issue = (state_d == ST_LOAD) && (load_cnt_d < LOAD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            load_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            k_re      <= 1'b0;
            k_addr0   <= '0;
            k_addr1   <= '0;
            k_we      <= 1'b0;
            k_idx     <= '0;
            img_re    <= 1'b0;
            mac_en    <= 1'b0;
            mac_clear <= 1'b0;
            mac_last  <= 1'b0;
            tap       <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            load_cnt  <= load_cnt_d;
            busy      <= (state_d != ST_IDLE);
            done      <= (state_d == ST_DONE);
            k_re      <= k_issue;
            k_addr0   <= k_issue ? {1'b0, load_cnt_d} : '0;
            k_addr1   <= k_issue ? KA_W'(K1_BASE) + {1'b0, load_cnt_d} : '0;
            k_we      <= k_re;
            k_idx     <= k_addr0[4:0];
            img_re    <= (state_d == ST_CONV);
            mac_en    <= img_re;
            mac_clear <= img_re && w_first;
            mac_last  <= img_re && w_last;
            tap       <= img_re ? w_tap : 5'd0;
            out_valid <= (state_d == ST_WRITE);
        end
    end

endmodule

// File: tb/tb_conv1_ctrl.sv
// Directed bench for conv1_ctrl: kernel load, window walk, backpressure,
// ignored start, full-pass timing and mid-pass reset.
module tb_conv1_ctrl;
    import conv1_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b1;
    logic        busy, done, k_re, k_we, img_re, mac_en, mac_clear, mac_last, out_valid;
    logic [5:0]  k_addr0, k_addr1;
    logic [4:0]  k_idx, tap;
    logic [9:0]  img_addr, out_addr;
    conv1_state_t dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc;
    int m_pix, m_tap, m_mac, hs_cnt, last_cnt, stall_cnt, exp_addr;
    bit done_seen, stalled_prev;

    always #5 clk = ~clk;

    conv1_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .k_addr0   (k_addr0),
        .k_addr1   (k_addr1),
        .k_re      (k_re),
        .k_we      (k_we),
        .k_idx     (k_idx),
        .img_addr  (img_addr),
        .img_re    (img_re),
        .mac_en    (mac_en),
        .mac_clear (mac_clear),
        .mac_last  (mac_last),
        .tap       (tap),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .dbg_state (dbg_state)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " k_re/k_we"}, 32'({k_re, k_we}), 0);
        chk({tag, " k_addr0"}, 32'(k_addr0), 0);
        chk({tag, " k_addr1"}, 32'(k_addr1), 0);
        chk({tag, " k_idx"}, 32'(k_idx), 0);
        chk({tag, " img_re"}, 32'(img_re), 0);
        chk({tag, " img_addr"}, 32'(img_addr), 0);
        chk({tag, " mac"}, 32'({mac_en, mac_clear, mac_last}), 0);
        chk({tag, " tap"}, 32'(tap), 0);
        chk({tag, " out_valid"}, 32'(out_valid), 0);
        chk({tag, " out_addr"}, 32'(out_addr), 0);
    endtask

    initial begin
        // Reset state
        #12;
        chk_all_zero("reset");
        #11;
        reset = 1'b1;
        tick();

        // Pass 1: stall at pixel 100, stray start at cycle 1000
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        m_pix = 0; m_tap = 0; m_mac = 0; hs_cnt = 0; last_cnt = 0; stall_cnt = 0;
        done_seen = 0; stalled_prev = 0;
        while (!done_seen && cyc < 20000) begin
            if (cyc == 1) begin
                chk("load c1 k_re", 32'(k_re), 1);
                chk("load c1 k_addr0", 32'(k_addr0), 0);
                chk("load c1 k_addr1", 32'(k_addr1), 25);
                chk("load c1 k_we", 32'(k_we), 0);
            end
            if (cyc == 2) begin
                chk("load c2 k_we", 32'(k_we), 1);
                chk("load c2 k_idx", 32'(k_idx), 0);
            end
            if (cyc == 25) begin
                chk("load c25 k_addr0", 32'(k_addr0), 24);
                chk("load c25 k_addr1", 32'(k_addr1), 49);
            end
            if (cyc == 26) begin
                chk("load c26 k_re", 32'(k_re), 0);
                chk("load c26 k_we", 32'(k_we), 1);
                chk("load c26 k_idx", 32'(k_idx), 24);
                chk("load c26 img_re", 32'(img_re), 0);
            end
            if (cyc == 27) begin
                chk("conv c27 img_re", 32'(img_re), 1);
                chk("conv c27 k_we", 32'(k_we), 0);
                chk("conv c27 mac_en", 32'(mac_en), 0);
            end
            if (cyc == 28) chk("c28 mac_clear", 32'(mac_clear), 1);
            if (cyc == 52) begin
                chk("drain c52 mac_last", 32'(mac_last), 1);
                chk("drain c52 img_re", 32'(img_re), 0);
            end
            if (cyc == 53) begin
                chk("c53 out_valid", 32'(out_valid), 1);
                chk("c53 out_addr", 32'(out_addr), 0);
            end
            if (cyc == 1000) chk("busy mid-pass", 32'(busy), 1);

            if (img_re) begin
                exp_addr = (m_pix / 24 + m_tap / 5) * 28 + (m_pix % 24) + (m_tap % 5);
                chk("img_addr", 32'(img_addr), 32'(exp_addr));
                if (m_pix == 24 && m_tap == 0) chk("row wrap first addr", 32'(img_addr), 28);
                if (m_pix == 575 && m_tap == 0) chk("last window first addr", 32'(img_addr), 667);
                if (m_pix == 575 && m_tap == 24) chk("last window last addr", 32'(img_addr), 783);
                m_tap = (m_tap == 24) ? 0 : m_tap + 1;
            end
            if (mac_en) begin
                chk("mac tap", 32'(tap), 32'(m_mac));
                chk("mac_clear", 32'(mac_clear), 32'(m_mac == 0));
                chk("mac_last", 32'(mac_last), 32'(m_mac == 24));
                if (mac_last) last_cnt++;
                m_mac = (m_mac == 24) ? 0 : m_mac + 1;
            end
            if (stalled_prev) begin
                chk("stall out_valid held", 32'(out_valid), 1);
                chk("stall out_addr held", 32'(out_addr), 100);
                chk("stall no img_re", 32'(img_re), 0);
            end
            if (done) begin
                done_seen = 1;
                chk("done cycle", 32'(cyc), 15589);
                chk("busy at done", 32'(busy), 1);
            end else begin
                if (out_valid && out_addr == 10'd100 && stall_cnt < 10) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    out_ready = 1'b1;
                end
                stalled_prev = out_valid && !out_ready;
                if (out_valid && out_ready) begin
                    chk("out_addr at handshake", 32'(out_addr), 32'(m_pix));
                    m_pix++;
                    hs_cnt++;
                end
                start = (cyc == 999);
                tick();
            end
        end
        start = 1'b0;
        if (!done_seen) chk("done timeout", 0, 1);
        chk("handshake count", 32'(hs_cnt), 576);
        chk("mac_last count", 32'(last_cnt), 576);
        chk("stall cycles", 32'(stall_cnt), 10);
        tick();
        chk("busy after done", 32'(busy), 0);
        chk("done pulse width", 32'(done), 0);
        chk("idle state", 32'(dbg_state), 32'(S_IDLE));

        // Pass 2: reset during CONV of pixel 300 (cycles 8127..8151)
        out_ready = 1'b1;
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        while (cyc < 8132) tick();
        chk("pix300 img_re", 32'(img_re), 1);
        chk("pix300 out_addr", 32'(out_addr), 300);
        chk("pix300 busy", 32'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        #2;
        reset = 1'b1;
        tick();
        chk("post-reset idle busy", 32'(busy), 0);
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        chk("reload c1 k_re", 32'(k_re), 1);
        chk("reload c1 k_addr0", 32'(k_addr0), 0);
        chk("reload c1 k_addr1", 32'(k_addr1), 25);
        tick();
        chk("reload c2 k_addr0", 32'(k_addr0), 1);
        chk("reload c2 k_we", 32'(k_we), 1);
        chk("reload c2 k_idx", 32'(k_idx), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
